// File: rtl/dmem_responder.sv
// Single-outstanding, big-endian data-memory responder with programmable wait states.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned and reserved-size accesses as errors.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              req_valid,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned Depth   = 1 << ADDR_W;
  localparam logic [3:0]  CntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                accept, commit;
  logic                rw_q, signed_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic [7:0]          mem [Depth];

  logic                op_rw, op_signed, op_err;
  logic [1:0]          op_size;
  logic [ADDR_W-1:0]   op_addr, eff_addr, a1, a2, a3;
  logic [31:0]         op_wdata, load_data;
  logic [7:0]          b0, b1, b2, b3;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !Reset) begin
      rw_q     <= req_rw;
      size_q   <= req_size;
      signed_q <= req_signed;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  // With zero wait states the commit edge is the accept edge, so use the live request.
  always_comb begin
    if (state_q == StIdle) begin
      op_rw     = req_rw;
      op_size   = req_size;
      op_signed = req_signed;
      op_addr   = req_addr;
      op_wdata  = req_wdata;
    end else begin
      op_rw     = rw_q;
      op_size   = size_q;
      op_signed = signed_q;
      op_addr   = addr_q;
      op_wdata  = wdata_q;
    end
  end

  always_comb begin
    eff_addr = op_addr;
    case (op_size)
      2'b00:   eff_addr = op_addr;
      2'b01:   eff_addr[0] = 1'b0;
      default: eff_addr[1:0] = 2'b00;
    endcase
  end

  assign a1 = eff_addr + ADDR_W'(1);
  assign a2 = eff_addr + ADDR_W'(2);
  assign a3 = eff_addr + ADDR_W'(3);
  assign b0 = mem[eff_addr];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    case (op_size)
      2'b00:   load_data = {{24{op_signed & b0[7]}}, b0};
      2'b01:   load_data = {{16{op_signed & b0[7]}}, b0, b1};
      default: load_data = {b0, b1, b2, b3};
    endcase
  end

  assign commit = !Reset && (state_d == StResp) && (state_q != StResp);

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;

  // A misaligned request is exactly one whose aligned-down address differs from the raw one.
  assign op_err = (eff_addr != op_addr) || (op_size == 2'b11);

  always_ff @(posedge clk) begin
    if (Reset)       err_q <= 1'b0;
    else if (commit) err_q <= op_err;
  end

  assign rsp_err = err_q;
`else
  assign op_err  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (commit && op_rw && !op_err) begin
      case (op_size)
        2'b00: mem[eff_addr] <= op_wdata[7:0];
        2'b01: begin
          mem[eff_addr] <= op_wdata[15:8];
          mem[a1]       <= op_wdata[7:0];
        end
        default: begin
          mem[eff_addr] <= op_wdata[31:24];
          mem[a1]       <= op_wdata[23:16];
          mem[a2]       <= op_wdata[15:8];
          mem[a3]       <= op_wdata[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset)       rdata_q <= 32'd0;
    else if (commit) rdata_q <= (op_rw || op_err) ? 32'd0 : load_data;
  end

  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table-driven requests with a response scoreboard, plus reset
// and zero-wait back-to-back sequences.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit Chk = 1'b1;
`else
  localparam bit Chk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset;
  logic        req_valid, req_rw, req_signed;
  logic [1:0]  req_size;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        busy, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid0, req_rw0;
  logic [7:0]  req_addr0;
  logic [31:0] req_wdata0;
  logic        busy0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut (
    .clk        (clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_rw     (req_rw),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk        (clk),
    .Reset      (Reset),
    .req_valid  (req_valid0),
    .req_rw     (req_rw0),
    .req_size   (2'b00),
    .req_signed (1'b0),
    .req_addr   (req_addr0),
    .req_wdata  (req_wdata0),
    .busy       (busy0),
    .rsp_valid  (rsp_valid0),
    .rsp_rdata  (rsp_rdata0),
    .rsp_err    (rsp_err0)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        sgn;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];
  rsp_t mon_e;
  int   errs   = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rw, input logic [1:0] size, input logic sgn,
                     input logic [7:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.rw = rw; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic do_req(input vec_t v);
    rsp_t e;
    int   n;
    @(negedge clk);
    req_valid = 1'b1; req_rw = v.rw; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata;
    e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 32'd3);
    @(negedge clk);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    chk("pulse_len", {31'd0, rsp_valid}, 32'd0);
    chk("rdata_hold", rsp_rdata, v.exp_rdata);
  endtask

  // Zero-wait instance: request held high, one response every second cycle, addresses FE..01.
  task automatic burst(input logic rw);
    logic [7:0] a;
    a = 8'hFE;
    @(negedge clk);
    req_valid0 = 1'b1; req_rw0 = rw; req_addr0 = a; req_wdata0 = {24'd0, a ^ 8'h5A};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b_valid", {31'd0, rsp_valid0}, {31'd0, (i % 2 == 0)});
      chk("b2b_busy", {31'd0, busy0}, {31'd0, (i % 2 == 0)});
      if (i % 2 == 0) begin
        chk("b2b_rdata", rsp_rdata0, rw ? 32'd0 : {24'd0, a ^ 8'h5A});
        chk("b2b_err", {31'd0, rsp_err0}, 32'd0);
        a = a + 8'd1;
        req_addr0 = a; req_wdata0 = {24'd0, a ^ 8'h5A};
      end
    end
    req_valid0 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
      end
    end
  end

  initial begin
    vec_t v;
    Reset = 1'b1;
    req_valid = 1'b0; req_rw = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 8'h00; req_wdata = 32'h0;
    req_valid0 = 1'b0; req_rw0 = 1'b0; req_addr0 = 8'h00; req_wdata0 = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    Reset = 1'b0;

    //  rw    size   sgn   addr   wdata          exp_rdata                  exp_err
    add(1'b1, 2'b10, 1'b0, 8'h10, 32'h11223344, 32'h0,                     1'b0);
    add(1'b0, 2'b10, 1'b0, 8'h10, 32'h0,        32'h11223344,              1'b0);
    add(1'b0, 2'b00, 1'b0, 8'h12, 32'h0,        32'h00000033,              1'b0);
    add(1'b1, 2'b10, 1'b0, 8'h20, 32'h80FF7F01, 32'h0,                     1'b0);
    add(1'b0, 2'b00, 1'b1, 8'h20, 32'h0,        32'hFFFFFF80,              1'b0);
    add(1'b0, 2'b01, 1'b0, 8'h22, 32'h0,        32'h00007F01,              1'b0);
    add(1'b0, 2'b01, 1'b1, 8'h20, 32'h0,        32'hFFFF80FF,              1'b0);
    add(1'b1, 2'b10, 1'b0, 8'h20, 32'h00000000, 32'h0,                     1'b0);
    add(1'b1, 2'b00, 1'b0, 8'h21, 32'h123456AB, 32'h0,                     1'b0);
    add(1'b0, 2'b10, 1'b0, 8'h20, 32'h0,        32'h00AB0000,              1'b0);
    add(1'b1, 2'b10, 1'b0, 8'h20, 32'hCAFEBABE, 32'h0,                     1'b0);
    add(1'b1, 2'b10, 1'b0, 8'h24, 32'hDEADBEEF, 32'h0,                     1'b0);
    add(1'b0, 2'b10, 1'b0, 8'h22, 32'h0,        Chk ? 32'h0 : 32'hCAFEBABE, Chk);
    add(1'b0, 2'b10, 1'b0, 8'h20, 32'h0,        32'hCAFEBABE,              1'b0);
    add(1'b1, 2'b10, 1'b0, 8'h26, 32'h01020304, 32'h0,                     Chk);
    add(1'b0, 2'b10, 1'b0, 8'h24, 32'h0,        Chk ? 32'hDEADBEEF : 32'h01020304, 1'b0);
    add(1'b0, 2'b11, 1'b0, 8'h20, 32'h0,        Chk ? 32'h0 : 32'hCAFEBABE, Chk);
    add(1'b0, 2'b00, 1'b1, 8'h21, 32'h0,        32'hFFFFFFFE,              1'b0);
    add(1'b0, 2'b01, 1'b1, 8'h27, 32'h0,        Chk ? 32'h0 : 32'h00000304, Chk);
    add(1'b1, 2'b10, 1'b0, 8'hFC, 32'hA1B2C3D4, 32'h0,                     1'b0);
    add(1'b0, 2'b01, 1'b0, 8'hFE, 32'h0,        32'h0000C3D4,              1'b0);
    add(1'b0, 2'b00, 1'b1, 8'hFF, 32'h0,        32'hFFFFFFD4,              1'b0);
    add(1'b1, 2'b10, 1'b0, 8'h30, 32'h55667788, 32'h0,                     1'b0);

    foreach (vecs[i]) do_req(vecs[i]);

    // Store aborted by reset during WAIT must not commit or respond.
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_addr = 8'h30;
    req_wdata = 32'h0BADF00D;
    @(negedge clk);
    req_valid = 1'b0;
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_rdata", rsp_rdata, 32'd0);
    repeat (4) @(negedge clk);
    v.rw = 1'b0; v.size = 2'b10; v.sgn = 1'b0; v.addr = 8'h30; v.wdata = 32'h0;
    v.exp_rdata = 32'h55667788; v.exp_err = 1'b0;
    do_req(v);

    // Reset and request in the same cycle: request is dropped.
    @(negedge clk);
    Reset = 1'b1; req_valid = 1'b1; req_rw = 1'b0; req_addr = 8'h10;
    @(negedge clk);
    Reset = 1'b0; req_valid = 1'b0;
    chk("rstreq_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("rstreq_busy2", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);

    burst(1'b1);
    @(negedge clk);
    burst(1'b0);
    @(negedge clk);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
